// File: rtl/fp_exp_pkg.sv
// Shared types and constants for the constant-time modular exponentiation controller.
package fp_exp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;

  localparam logic [1:0] MODE_RAW   = 2'b00;
  localparam logic [1:0] MODE_LEG   = 2'b01;
  localparam logic [1:0] MODE_INV   = 2'b10;
  localparam logic [1:0] MODE_TWIST = 2'b11;

  // CSIDH-512 prime and Montgomery one (2^512 mod p).
  localparam logic [511:0] CSIDH512_P =
    512'h65b48e8f740f89bffc8ab0d15e3e4c4ab42d083aedc88c425afbfcc69322c9cda7aac6c567f35507516730cc1f0b4f25c2721bf457aca8351b81b90533c6c87b;
  localparam logic [511:0] CSIDH512_R =
    512'h3496e2e117e0ec8006ea9e5d4383676a97a5ef8a246ee77b4a080672d9ba6c64b0aa7275301955f15d319e67c1e961b47b1bc81750a6af95c8fc8df598726f0a;

endpackage

// File: rtl/fp_exp_engine.sv
// Square-and-multiply-always exponentiation controller driving an external shared
// field multiplier/adder; four modes (raw, Legendre, inverse, twist check).
module fp_exp_engine
  import fp_exp_pkg::*;
#(
  parameter int unsigned      N     = 512,
  parameter int unsigned      EXP_W = 512,
  parameter logic [N-1:0]     P     = N'(CSIDH512_P),
  parameter logic [N-1:0]     ONE_M = N'(CSIDH512_R),
  parameter logic [EXP_W-1:0] PM1H  = EXP_W'(P >> 1),
  parameter logic [EXP_W-1:0] PM2   = EXP_W'(P - N'(2))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     ax,
  input  logic [EXP_W-1:0] e,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  output logic [1:0]       mul_op,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [N-1:0]     mul_res,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
  output logic             is_qr,
  output logic             is_zero,
  output logic             twist,
  output logic [2:0]       state_dbg
);

  localparam int CW = $clog2(EXP_W) + 1;

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     base_q, base_d;
  logic [N-1:0]     xin_q, xin_d;
  logic [N-1:0]     ax_q, ax_d;
  logic [EXP_W-1:0] ex_q, ex_d;
  logic [1:0]       mode_q, mode_d;
  logic             in_pre_q, in_pre_d;
  logic [1:0]       pre_q, pre_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             sub_q, sub_d;
  logic [N-1:0]     mul_a_q, mul_a_d;
  logic [N-1:0]     mul_b_q, mul_b_d;
  logic [1:0]       mul_op_q, mul_op_d;
  logic             mul_start_q, mul_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     result_q, result_d;
  logic             is_qr_q, is_qr_d;
  logic             is_zero_q, is_zero_d;
  logic             twist_q, twist_d;
  logic             load_ops;
  logic             ex_bit;
  logic             last_op;

  assign ex_bit  = |(ex_q & (EXP_W'(1) << bit_q));
  assign last_op = !in_pre_q && sub_q && (bit_q == '0);

  // Handshake: start is accepted only in IDLE while done is low; mul_start is a
  // one-cycle request and mul_done is honoured only in WAIT, with operands held
  // in registers from ISSUE until the result is captured.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    base_d      = base_q;
    xin_d       = xin_q;
    ax_d        = ax_q;
    ex_d        = ex_q;
    mode_d      = mode_q;
    in_pre_d    = in_pre_q;
    pre_d       = pre_q;
    bit_d       = bit_q;
    sub_d       = sub_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_op_d    = mul_op_q;
    mul_start_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    is_qr_d     = is_qr_q;
    is_zero_d   = is_zero_q;
    twist_d     = twist_q;
    load_ops    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          mode_d    = mode;
          xin_d     = x;
          ax_d      = ax;
          acc_d     = ONE_M;
          base_d    = (mode == MODE_TWIST) ? '0 : x;
          in_pre_d  = (mode == MODE_TWIST);
          pre_d     = 2'd0;
          bit_d     = CW'(EXP_W - 1);
          sub_d     = 1'b0;
          result_d  = '0;
          is_qr_d   = 1'b0;
          is_zero_d = 1'b0;
          twist_d   = 1'b0;
          busy_d    = 1'b1;
          load_ops  = 1'b1;
          state_d   = S_ISSUE;
          case (mode)
            MODE_RAW: ex_d = e;
            MODE_INV: ex_d = PM2;
            default:  ex_d = PM1H;
          endcase
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          if (in_pre_q)           base_d = mul_res;
          else if (!sub_q)        acc_d  = mul_res;
          else if (ex_bit)        acc_d  = mul_res;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_op) begin
          state_d = S_FIN;
        end else begin
          if (in_pre_q) begin
            if (pre_q == 2'd3) in_pre_d = 1'b0;
            else               pre_d    = pre_q + 2'd1;
          end else if (!sub_q) begin
            sub_d = 1'b1;
          end else begin
            sub_d = 1'b0;
            bit_d = bit_q - CW'(1);
          end
          load_ops = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_FIN: begin
        is_zero_d = (base_q == '0);
        result_d  = is_zero_d ? '0 : acc_q;
        is_qr_d   = !is_zero_d && (acc_q == ONE_M);
        twist_d   = (mode_q == MODE_TWIST) && !is_qr_d && !is_zero_d;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Operands are chosen from the next-cycle view so they are already stable in ISSUE.
    if (load_ops) begin
      mul_start_d = 1'b1;
      if (in_pre_d) begin
        case (pre_d)
          2'd0:    begin mul_a_d = xin_d;  mul_b_d = ax_d;  mul_op_d = OP_ADD; end
          2'd1:    begin mul_a_d = base_d; mul_b_d = xin_d; mul_op_d = OP_MUL; end
          2'd2:    begin mul_a_d = base_d; mul_b_d = ONE_M; mul_op_d = OP_ADD; end
          default: begin mul_a_d = base_d; mul_b_d = xin_d; mul_op_d = OP_MUL; end
        endcase
      end else if (!sub_d) begin
        mul_a_d  = acc_d;
        mul_b_d  = acc_d;
        mul_op_d = OP_MUL;
      end else begin
        mul_a_d  = acc_d;
        mul_b_d  = base_d;
        mul_op_d = OP_MUL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      base_q      <= '0;
      xin_q       <= '0;
      ax_q        <= '0;
      ex_q        <= '0;
      mode_q      <= 2'b00;
      in_pre_q    <= 1'b0;
      pre_q       <= 2'd0;
      bit_q       <= '0;
      sub_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_op_q    <= 2'b00;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      is_qr_q     <= 1'b0;
      is_zero_q   <= 1'b0;
      twist_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      xin_q       <= xin_d;
      ax_q        <= ax_d;
      ex_q        <= ex_d;
      mode_q      <= mode_d;
      in_pre_q    <= in_pre_d;
      pre_q       <= pre_d;
      bit_q       <= bit_d;
      sub_q       <= sub_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_op_q    <= mul_op_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      is_qr_q     <= is_qr_d;
      is_zero_q   <= is_zero_d;
      twist_q     <= twist_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_op    = mul_op_q;
  assign mul_start = mul_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign is_qr     = is_qr_q;
  assign is_zero   = is_zero_q;
  assign twist     = twist_q;
  assign state_dbg = state_q;

endmodule
